// File: rtl/joy_pkg.sv
// Shared definitions for the DB15 joystick serial link (receiver and responder).
package joy_pkg;

   localparam int PLAYER_BITS_DEF = 16;
   localparam int FRAME_BITS_DEF  = 2 * PLAYER_BITS_DEF;

   // Bit positions inside one player word, layout LS FEDCBAUDLR.
   localparam int JOY_BIT_RIGHT    = 0;
   localparam int JOY_BIT_LEFT     = 1;
   localparam int JOY_BIT_DOWN     = 2;
   localparam int JOY_BIT_UP       = 3;
   localparam int JOY_BIT_A        = 4;
   localparam int JOY_BIT_B        = 5;
   localparam int JOY_BIT_C        = 6;
   localparam int JOY_BIT_D        = 7;
   localparam int JOY_BIT_E        = 8;
   localparam int JOY_BIT_F        = 9;
   localparam int JOY_BIT_START    = 10;
   localparam int JOY_BIT_SHOULDER = 11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } joy_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous input, followed by registered
// rise/fall pulses. Level and pulses are aligned to the same clock cycle.
module sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   prev_r;
   logic                   rise_r;
   logic                   fall_r;

   // Metastability chain; idles high so a released line looks inactive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r <= {SYNC_STAGES{1'b1}};
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
      end
   end

   // Edge detector: remembers the last synced level and registers the pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_r <= 1'b1;
         rise_r <= 1'b0;
         fall_r <= 1'b0;
      end else begin
         prev_r <= sync_r[SYNC_STAGES-1];
         rise_r <= ~prev_r & sync_r[SYNC_STAGES-1];
         fall_r <= prev_r & ~sync_r[SYNC_STAGES-1];
      end
   end

   assign level = prev_r;
   assign rise  = rise_r;
   assign fall  = fall_r;

endmodule

// File: rtl/joy_db15_responder.sv
// Device side of the DB15 serial joystick link: behaves like the 74HC165 chain
// in the adapter, shifting both player words out active-low, LSB first.
module joy_db15_responder
   import joy_pkg::*;
#(
   parameter int PLAYER_BITS = PLAYER_BITS_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic                               clk_sys,
   input  logic                               I_RESETn,
   input  logic [PLAYER_BITS-1:0]             joystick1,
   input  logic [PLAYER_BITS-1:0]             joystick2,
   input  logic                               JOY_LOAD,
   input  logic                               JOY_CLK,
   output logic                               JOY_DATA,
   output logic                               frame_done,
   output logic                               overrun,
   output logic [$clog2(2*PLAYER_BITS):0]     bit_cnt
);

   localparam int FRAME_BITS = 2 * PLAYER_BITS;
   localparam int CNT_W      = $clog2(FRAME_BITS) + 1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS);

   logic             load_level_s;
   logic             clk_fall_s;
   logic             load_rise_unused;
   logic             load_fall_unused;
   logic             clk_level_unused;
   logic             clk_rise_unused;
   logic [CNT_W-1:0] cnt_next_s;

   // JOY_DATA itself holds frame bit 0, so the register only keeps bits 1..N-1.
   logic [FRAME_BITS-2:0] shift_r;
   joy_state_t            state_r;

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
      .clk      (clk_sys),
      .rst_n    (I_RESETn),
      .async_in (JOY_CLK),
      .level    (clk_level_unused),
      .rise     (clk_rise_unused),
      .fall     (clk_fall_s)
   );

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_load (
      .clk      (clk_sys),
      .rst_n    (I_RESETn),
      .async_in (JOY_LOAD),
      .level    (load_level_s),
      .rise     (load_rise_unused),
      .fall     (load_fall_unused)
   );

   assign cnt_next_s = bit_cnt + CNT_ONE;

   // Frame state machine; a low load level overrides every state and any clock edge.
   always_ff @(posedge clk_sys or negedge I_RESETn) begin
      if (!I_RESETn) begin
         state_r    <= IDLE;
         shift_r    <= {(FRAME_BITS-1){1'b1}};
         JOY_DATA   <= 1'b1;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
         bit_cnt    <= {CNT_W{1'b0}};
      end else begin
         frame_done <= 1'b0;
         if (!load_level_s) begin
            // Transparent parallel load: inputs are re-sampled every cycle while low.
            state_r  <= LOAD;
            shift_r  <= ~{joystick2, joystick1[PLAYER_BITS-1:1]};
            JOY_DATA <= ~joystick1[0];
            bit_cnt  <= {CNT_W{1'b0}};
            overrun  <= 1'b0;
         end else begin
            case (state_r)
               IDLE: begin
                  JOY_DATA <= 1'b1;
               end
               LOAD: begin
                  state_r <= SHIFT;
               end
               SHIFT: begin
                  if (clk_fall_s) begin
                     shift_r <= {1'b1, shift_r[FRAME_BITS-2:1]};
                     bit_cnt <= cnt_next_s;
                     if (cnt_next_s == CNT_LAST) begin
                        JOY_DATA   <= 1'b1;
                        frame_done <= 1'b1;
                        state_r    <= DONE;
                     end else begin
                        JOY_DATA <= shift_r[0];
                     end
                  end
               end
               DONE: begin
                  JOY_DATA <= 1'b1;
                  if (clk_fall_s) begin
                     overrun <= 1'b1;
                  end
               end
               default: begin
                  state_r  <= IDLE;
                  JOY_DATA <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule
